rf_wport_arb: RTL and testbench

- Arbitrates the single GPR register-file write port between the in-order pipeline write-back bus (we/waddr/wdata from the WB stage) and one long-latency result source (multi-cycle divider or uncached-load return).
- Holds a one-entry skid buffer for the long-latency result.
- Keeps a 32-bit pending-write scoreboard so decode can stall on registers whose long-latency result is outstanding.
- Sits between the WB stage, the long-latency unit, the decode stage and the regfile.

---
 rtl/rf_wport_arb_pkg.sv | 31 +++
 rtl/rf_wport_arb_if.sv | 43 ++++
 rtl/rf_wport_arb_scoreboard.sv | 47 ++++
 rtl/rf_wport_arb.sv | 95 +++++++++
 tb/tb_rf_wport_arb.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/rf_wport_arb_pkg.sv
// Shared types for the register-file write-port arbiter: bus packings,
// grant encoding and the scoreboard query helper.
package rf_wport_arb_pkg;

    localparam int RF_WPORT_BUS_WD   = 38;
    localparam int LU_TO_ARB_BUS_WD  = 37;

    // Same field order as the WB-to-RF bus, so it can be driven onto rf_* directly
    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_wport_t;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } lu_bus_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WS   = 2'd1,
        GNT_BUF  = 2'd2
    } grant_e;

    // Register 0 is hard-wired, so it is never reported as busy
    function automatic logic reg_busy(input logic [31:0] pend, input logic [4:0] addr);
        return (addr != 5'd0) && pend[addr];
    endfunction

endpackage

// File: rtl/rf_wport_arb_if.sv
// Signal bundle between the pipeline (WB, decode, long-latency unit, regfile)
// and the write-port arbiter. The arbiter uses the slave view.
interface rf_wport_arb_if;
    logic        ws_we;
    logic [4:0]  ws_waddr;
    logic [31:0] ws_wdata;
    logic        ws_hold;

    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_dest;
    logic [31:0] lu_data;

    logic        claim_valid;
    logic [4:0]  claim_dest;
    logic        claim_ready;

    logic [4:0]  q_rs;
    logic [4:0]  q_rt;
    logic [4:0]  q_rd;
    logic        rs_busy;
    logic        rt_busy;
    logic        rd_busy;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        lu_commit;

    modport master (
        output ws_we, ws_waddr, ws_wdata, lu_valid, lu_dest, lu_data,
               claim_valid, claim_dest, q_rs, q_rt, q_rd,
        input  ws_hold, lu_ready, claim_ready, rs_busy, rt_busy, rd_busy,
               rf_we, rf_waddr, rf_wdata, lu_commit
    );

    modport slave (
        input  ws_we, ws_waddr, ws_wdata, lu_valid, lu_dest, lu_data,
               claim_valid, claim_dest, q_rs, q_rt, q_rd,
        output ws_hold, lu_ready, claim_ready, rs_busy, rt_busy, rd_busy,
               rf_we, rf_waddr, rf_wdata, lu_commit
    );
endinterface

// File: rtl/rf_wport_arb_scoreboard.sv
// Pending-write scoreboard: one bit per GPR that has a long-latency result
// outstanding. Decode claims a bit at issue; the arbiter clears it on commit.
module rf_scoreboard
    import rf_wport_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       claim_valid,
    input  logic [4:0] claim_dest,
    output logic       claim_ready,
    input  logic       clr_en,
    input  logic [4:0] clr_dest,
    input  logic [4:0] q_rs,
    input  logic [4:0] q_rt,
    input  logic [4:0] q_rd,
    output logic       rs_busy,
    output logic       rt_busy,
    output logic       rd_busy
);

    logic [31:0] pend;
    logic [31:0] pend_next;

    assign claim_ready = (claim_dest == 5'd0) || !pend[claim_dest];

    // Clear first, then set, so a same-cycle claim of the committing register keeps it pending
    always_comb begin
        pend_next = pend;
        if (clr_en && (clr_dest != 5'd0))
            pend_next[clr_dest] = 1'b0;
        if (claim_valid && claim_ready && (claim_dest != 5'd0))
            pend_next[claim_dest] = 1'b1;
    end

    // Pending bit register
    always_ff @(posedge clk) begin
        if (reset)
            pend <= '0;
        else
            pend <= pend_next;
    end

    assign rs_busy = reg_busy(pend, q_rs);
    assign rt_busy = reg_busy(pend, q_rt);
    assign rd_busy = reg_busy(pend, q_rd);

endmodule

// File: rtl/rf_wport_arb.sv
// GPR write-port arbiter: WB write-back normally wins, the one-entry
// long-latency skid buffer takes idle cycles, and after STARVE_LIMIT lost
// cycles the WB stage is held for one cycle so the buffer can drain.
module rf_wport_arb
    import rf_wport_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int SC_W         = 3
) (
    input  logic clk,
    input  logic reset,
    rf_wport_arb_if.slave bus
);

    localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

    logic            buf_valid;
    lu_bus_t         buf_q;
    logic [SC_W-1:0] starve_cnt;
    logic            hold;
    logic            commit;
    grant_e          grant;
    rf_wport_t       port;

    assign hold = buf_valid && (starve_cnt == LIMIT);

    // Fixed-priority grant: forced drain, then WB, then opportunistic drain
    always_comb begin
        grant = GNT_NONE;
        if (hold)
            grant = GNT_BUF;
        else if (bus.ws_we)
            grant = GNT_WS;
        else if (buf_valid)
            grant = GNT_BUF;
    end

    // Steer the granted source onto the regfile write port
    always_comb begin
        port = '0;
        case (grant)
            GNT_WS:  port = '{we: 1'b1, waddr: bus.ws_waddr, wdata: bus.ws_wdata};
            GNT_BUF: port = '{we: 1'b1, waddr: buf_q.dest, wdata: buf_q.data};
            default: port = '0;
        endcase
    end

    assign commit        = (grant == GNT_BUF);
    assign bus.ws_hold   = hold;
    assign bus.lu_ready  = !buf_valid;
    assign bus.lu_commit = commit;
    assign bus.rf_we     = port.we;
    assign bus.rf_waddr  = port.waddr;
    assign bus.rf_wdata  = port.wdata;

    // Skid buffer: accept only when empty, drain on commit; no write-through
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_q     <= '0;
        end else if (commit) begin
            buf_valid <= 1'b0;
        end else if (bus.lu_valid && !buf_valid) begin
            buf_valid <= 1'b1;
            buf_q     <= '{dest: bus.lu_dest, data: bus.lu_data};
        end
    end

    // Count cycles the buffered result loses the port to WB
    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= '0;
        else if (commit)
            starve_cnt <= '0;
        else if (buf_valid && bus.ws_we && !hold)
            starve_cnt <= starve_cnt + 1'b1;
    end

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .claim_valid (bus.claim_valid),
        .claim_dest  (bus.claim_dest),
        .claim_ready (bus.claim_ready),
        .clr_en      (commit),
        .clr_dest    (buf_q.dest),
        .q_rs        (bus.q_rs),
        .q_rt        (bus.q_rt),
        .q_rd        (bus.q_rd),
        .rs_busy     (bus.rs_busy),
        .rt_busy     (bus.rt_busy),
        .rd_busy     (bus.rd_busy)
    );

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed, table-driven bench for rf_wport_arb: each table row is one clock
// cycle of inputs with the combinational outputs expected in that cycle.
module tb_rf_wport_arb;

    logic clk;
    logic reset;

    rf_wport_arb_if bus();

    rf_wport_arb #(.STARVE_LIMIT(4), .SC_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ws_we;
        logic [4:0]  ws_waddr;
        logic [31:0] ws_wdata;
        logic        lu_valid;
        logic [4:0]  lu_dest;
        logic [31:0] lu_data;
        logic        claim_valid;
        logic [4:0]  claim_dest;
        logic [4:0]  q_rs;
        logic [4:0]  q_rt;
        logic [4:0]  q_rd;
    } in_t;

    typedef struct {
        logic        ws_hold;
        logic        lu_ready;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        lu_commit;
        logic        claim_ready;
        logic        rs_busy;
        logic        rt_busy;
        logic        rd_busy;
    } ex_t;

    typedef struct {
        in_t i;
        ex_t e;
    } vec_t;

    vec_t tbl[$];
    int   checks;
    int   failures;

    function automatic in_t mkin(logic we, logic [4:0] wa, logic [31:0] wd,
                                 logic lv, logic [4:0] ld, logic [31:0] ldat,
                                 logic cv, logic [4:0] cd,
                                 logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        in_t r;
        r.ws_we = we; r.ws_waddr = wa; r.ws_wdata = wd;
        r.lu_valid = lv; r.lu_dest = ld; r.lu_data = ldat;
        r.claim_valid = cv; r.claim_dest = cd;
        r.q_rs = rs; r.q_rt = rt; r.q_rd = rd;
        return r;
    endfunction

    function automatic ex_t mkex(logic h, logic lr, logic we, logic [4:0] wa, logic [31:0] wd,
                                 logic cm, logic cr, logic bs, logic bt, logic bd);
        ex_t r;
        r.ws_hold = h; r.lu_ready = lr; r.rf_we = we; r.rf_waddr = wa; r.rf_wdata = wd;
        r.lu_commit = cm; r.claim_ready = cr;
        r.rs_busy = bs; r.rt_busy = bt; r.rd_busy = bd;
        return r;
    endfunction

    function automatic void add(in_t i, ex_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        tbl.push_back(v);
    endfunction

    task automatic cmp(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s row=%0d actual=0x%0h required=0x%0h", name, row, act, exp);
        end
    endtask

    task automatic applyStimulus(input in_t i);
        bus.ws_we       = i.ws_we;
        bus.ws_waddr    = i.ws_waddr;
        bus.ws_wdata    = i.ws_wdata;
        bus.lu_valid    = i.lu_valid;
        bus.lu_dest     = i.lu_dest;
        bus.lu_data     = i.lu_data;
        bus.claim_valid = i.claim_valid;
        bus.claim_dest  = i.claim_dest;
        bus.q_rs        = i.q_rs;
        bus.q_rt        = i.q_rt;
        bus.q_rd        = i.q_rd;
    endtask

    task automatic checkOutput(input ex_t e, input int row);
        cmp("ws_hold",     row, 32'(bus.ws_hold),     32'(e.ws_hold));
        cmp("lu_ready",    row, 32'(bus.lu_ready),    32'(e.lu_ready));
        cmp("rf_we",       row, 32'(bus.rf_we),       32'(e.rf_we));
        if (e.rf_we) begin
            cmp("rf_waddr", row, 32'(bus.rf_waddr), 32'(e.rf_waddr));
            cmp("rf_wdata", row, bus.rf_wdata,      e.rf_wdata);
        end
        cmp("lu_commit",   row, 32'(bus.lu_commit),   32'(e.lu_commit));
        cmp("claim_ready", row, 32'(bus.claim_ready), 32'(e.claim_ready));
        cmp("rs_busy",     row, 32'(bus.rs_busy),     32'(e.rs_busy));
        cmp("rt_busy",     row, 32'(bus.rt_busy),     32'(e.rt_busy));
        cmp("rd_busy",     row, 32'(bus.rd_busy),     32'(e.rd_busy));
    endtask

    initial begin
        in_t idle;
        ex_t dflt;
        checks   = 0;
        failures = 0;
        idle = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dflt = mkex(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);

        // Reset state and idle-port commit
        add(idle, dflt);                                                                        // 0
        add(mkin(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0), dflt);                            // 1
        add(idle, mkex(0, 0, 1, 5, 32'hDEADBEEF, 1, 1, 0, 0, 0));                               // 2
        add(idle, dflt);                                                                        // 3
        // Collision: WB wins twice, then the buffer drains
        add(mkin(0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 0, 0), dflt);                                  // 4
        add(mkin(1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0), mkex(0, 0, 1, 3, 32'h33, 0, 1, 0, 0, 0)); // 5
        add(mkin(1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0), mkex(0, 0, 1, 3, 32'h33, 0, 1, 0, 0, 0)); // 6
        add(idle, mkex(0, 0, 1, 7, 32'h77, 1, 1, 0, 0, 0));                                     // 7
        add(idle, dflt);                                                                        // 8
        // Starvation: four lost cycles, one forced drain, then the held WB write
        add(mkin(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0, 0), dflt);                                  // 9
        add(mkin(1, 1, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0), mkex(0, 0, 1, 1, 32'h11, 0, 1, 0, 0, 0)); // 10
        add(mkin(1, 2, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0), mkex(0, 0, 1, 2, 32'h22, 0, 1, 0, 0, 0)); // 11
        add(mkin(1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0), mkex(0, 0, 1, 3, 32'h33, 0, 1, 0, 0, 0)); // 12
        add(mkin(1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 0, 0), mkex(0, 0, 1, 6, 32'h66, 0, 1, 0, 0, 0)); // 13
        add(mkin(1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0), mkex(1, 0, 1, 9, 32'h99, 1, 1, 0, 0, 0)); // 14
        add(mkin(1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0), mkex(0, 1, 1, 4, 32'h44, 0, 1, 0, 0, 0)); // 15
        add(idle, dflt);                                                                        // 16
        // Scoreboard claim, duplicate claim, commit clears
        add(mkin(0, 0, 0, 0, 0, 0, 1, 12, 12, 0, 0), dflt);                                     // 17
        add(mkin(0, 0, 0, 1, 12, 32'hC0DE, 1, 12, 12, 0, 0), mkex(0, 1, 0, 0, 0, 0, 0, 1, 0, 0)); // 18
        add(mkin(0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0), mkex(0, 0, 1, 12, 32'hC0DE, 1, 1, 1, 0, 0));  // 19
        add(mkin(0, 0, 0, 0, 0, 0, 0, 12, 12, 0, 0), dflt);                                     // 20
        // Non-pending result for 12 commits in the same cycle a claim of 12 lands
        add(mkin(0, 0, 0, 1, 12, 32'h1212, 0, 0, 12, 0, 0), dflt);                              // 21
        add(mkin(0, 0, 0, 0, 0, 0, 1, 12, 12, 0, 0), mkex(0, 0, 1, 12, 32'h1212, 1, 1, 0, 0, 0)); // 22
        add(mkin(0, 0, 0, 0, 0, 0, 0, 12, 12, 0, 0), mkex(0, 1, 0, 0, 0, 0, 0, 1, 0, 0));       // 23
        // Register 0: claims set nothing, queries never busy, commits clear nothing
        add(mkin(0, 0, 0, 0, 0, 0, 1, 0, 12, 0, 0), mkex(0, 1, 0, 0, 0, 0, 1, 1, 0, 0));        // 24
        add(mkin(0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 12), mkex(0, 1, 0, 0, 0, 0, 1, 1, 0, 1));       // 25
        add(mkin(0, 0, 0, 1, 0, 32'hABCD, 0, 0, 12, 0, 0), mkex(0, 1, 0, 0, 0, 0, 1, 1, 0, 0)); // 26
        add(mkin(0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0), mkex(0, 0, 1, 0, 32'hABCD, 1, 1, 1, 0, 0)); // 27
        add(mkin(0, 0, 0, 0, 0, 0, 0, 0, 12, 12, 0), mkex(0, 1, 0, 0, 0, 0, 1, 1, 1, 0));       // 28

        reset = 1'b1;
        applyStimulus(idle);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            applyStimulus(tbl[k].i);
            #1;
            checkOutput(tbl[k].e, k);
            @(posedge clk);
            #1;
        end

        // Reset mid-operation: pend[12] is set; load the buffer, then reset
        applyStimulus(mkin(0, 0, 0, 1, 5, 32'h5555, 0, 0, 12, 12, 12));
        #1;
        checkOutput(mkex(0, 1, 0, 0, 0, 0, 1, 1, 1, 1), 100);
        @(posedge clk);
        #1;
        applyStimulus(mkin(0, 0, 0, 0, 0, 0, 0, 0, 12, 12, 12));
        #1;
        checkOutput(mkex(0, 0, 1, 5, 32'h5555, 1, 1, 1, 1, 1), 101);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput(mkex(0, 1, 0, 0, 0, 0, 1, 0, 0, 0), 102);

        // Reset with the buffer still full
        applyStimulus(mkin(1, 3, 32'h3, 1, 12, 32'h12, 0, 0, 12, 12, 12));
        @(posedge clk);
        #1;
        applyStimulus(mkin(1, 3, 32'h3, 0, 0, 0, 1, 12, 12, 12, 12));
        #1;
        checkOutput(mkex(0, 0, 1, 3, 32'h3, 0, 1, 0, 0, 0), 103);
        @(posedge clk);
        #1;
        applyStimulus(mkin(0, 0, 0, 0, 0, 0, 0, 12, 12, 12, 12));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput(mkex(0, 1, 0, 0, 0, 0, 1, 0, 0, 0), 104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
